aud_mode_ctrl: RTL and testbench

Top-level mode sequencer for the Lab3 audio recorder/player. It turns debounced key pulses into start/pause/stop pulses for the recorder and for AudDSP, and tracks the recorded length. It ends playback automatically at the end of the recording. It also owns the single shared SRAM port and multiplexes it between the recorder (write) and AudDSP (read).

---
 rtl/aud_mode_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_aud_mode_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aud_mode_ctrl.sv
// Mode sequencer for the audio recorder/player: key pulses to recorder/DSP
// control pulses, recorded-length tracking and the shared SRAM port mux.
module aud_mode_ctrl #(
    parameter int          ADDR_W   = 20,
    parameter int unsigned MAX_ADDR = 2**20 - 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_key_record,
    input  logic              i_key_play,
    input  logic              i_key_pause,
    input  logic              i_key_stop,
    input  logic [2:0]        i_speed,
    input  logic              i_fast,
    input  logic              i_interp,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    input  logic              i_rec_we,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [15:0]       i_rec_data,
    output logic              o_dsp_start,
    output logic              o_dsp_pause,
    output logic              o_dsp_stop,
    output logic [2:0]        o_dsp_speed,
    output logic              o_dsp_fast,
    output logic              o_dsp_interp,
    input  logic [ADDR_W-1:0] i_dsp_addr,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [15:0]       o_sram_wdata,
    output logic              o_sram_we_n,
    output logic              o_sram_oe_n,
    output logic [2:0]        o_state,
    output logic [ADDR_W-1:0] o_rec_len
);

    localparam int LW = ADDR_W + 1;
    localparam logic [ADDR_W:0]   LEN_FULL  = LW'(MAX_ADDR) + LW'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MAX_ADDR);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_REC        = 3'd1,
        S_REC_PAUSE  = 3'd2,
        S_PLAY       = 3'd3,
        S_PLAY_PAUSE = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [ADDR_W:0] len_q, len_d;
    logic [2:0]      speed_q, speed_d;
    logic            fast_q, fast_d;
    logic            interp_q, interp_d;
    logic            rec_start_d, rec_pause_d, rec_stop_d;
    logic            dsp_start_d, dsp_pause_d, dsp_stop_d;

    logic [ADDR_W:0] wr_len;
    logic [ADDR_W:0] wr_len_sat;
    logic            full_wr;
    logic            play_end;

    // Length is one wider than the address so a full memory is representable
    assign wr_len     = {1'b0, i_rec_addr} + LW'(1);
    assign wr_len_sat = (wr_len > LEN_FULL) ? LEN_FULL : wr_len;
    assign full_wr    = i_rec_we && (i_rec_addr == ADDR_LAST);
    assign play_end   = ({1'b0, i_dsp_addr} >= len_q);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            speed_q      <= 3'd1;
            fast_q       <= 1'b0;
            interp_q     <= 1'b0;
            o_rec_start  <= 1'b0;
            o_rec_pause  <= 1'b0;
            o_rec_stop   <= 1'b0;
            o_dsp_start  <= 1'b0;
            o_dsp_pause  <= 1'b0;
            o_dsp_stop   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            speed_q      <= speed_d;
            fast_q       <= fast_d;
            interp_q     <= interp_d;
            o_rec_start  <= rec_start_d;
            o_rec_pause  <= rec_pause_d;
            o_rec_stop   <= rec_stop_d;
            o_dsp_start  <= dsp_start_d;
            o_dsp_pause  <= dsp_pause_d;
            o_dsp_stop   <= dsp_stop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        speed_d     = speed_q;
        fast_d      = fast_q;
        interp_d    = interp_q;
        rec_start_d = 1'b0;
        rec_pause_d = 1'b0;
        rec_stop_d  = 1'b0;
        dsp_start_d = 1'b0;
        dsp_pause_d = 1'b0;
        dsp_stop_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_key_record) begin
                    state_d     = S_REC;
                    rec_start_d = 1'b1;
                    len_d       = '0;
                end else if (i_key_play && len_q != '0) begin
                    state_d     = S_PLAY;
                    dsp_start_d = 1'b1;
                    speed_d     = (i_speed == 3'd0) ? 3'd1 : i_speed;
                    fast_d      = i_fast;
                    interp_d    = i_interp;
                end
            end
            S_REC: begin
                if (i_rec_we) len_d = wr_len_sat;
                // Filling the last word behaves exactly like a stop key
                if (i_key_stop || full_wr) begin
                    state_d    = S_IDLE;
                    rec_stop_d = 1'b1;
                end else if (i_key_pause) begin
                    state_d     = S_REC_PAUSE;
                    rec_pause_d = 1'b1;
                end
            end
            S_REC_PAUSE: begin
                if (i_key_stop) begin
                    state_d    = S_IDLE;
                    rec_stop_d = 1'b1;
                end else if (i_key_record) begin
                    state_d     = S_REC;
                    rec_start_d = 1'b1;
                end
            end
            S_PLAY: begin
                if (i_key_stop || play_end) begin
                    state_d    = S_IDLE;
                    dsp_stop_d = 1'b1;
                end else if (i_key_pause) begin
                    state_d     = S_PLAY_PAUSE;
                    dsp_pause_d = 1'b1;
                end
            end
            S_PLAY_PAUSE: begin
                if (i_key_stop) begin
                    state_d    = S_IDLE;
                    dsp_stop_d = 1'b1;
                end else if (i_key_play) begin
                    state_d     = S_PLAY;
                    dsp_start_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        o_sram_we_n  = 1'b1;
        o_sram_oe_n  = 1'b1;
        unique case (state_q)
            S_REC: begin
                o_sram_addr  = i_rec_addr;
                o_sram_wdata = i_rec_data;
                o_sram_we_n  = ~i_rec_we;
            end
            S_PLAY, S_PLAY_PAUSE: begin
                o_sram_addr = i_dsp_addr;
                o_sram_oe_n = 1'b0;
            end
            default: ;
        endcase
    end

    assign o_state      = state_q;
    assign o_rec_len    = (len_q >= LEN_FULL) ? '1 : len_q[ADDR_W-1:0];
    assign o_dsp_speed  = speed_q;
    assign o_dsp_fast   = fast_q;
    assign o_dsp_interp = interp_q;

endmodule

// File: tb/tb_aud_mode_ctrl.sv
// Directed plus randomized bench for aud_mode_ctrl against a behavioural
// model of the recorder/player mode rules.
module tb_aud_mode_ctrl;

    localparam int          ADDR_W   = 20;
    localparam int unsigned MAX_ADDR = 2**20 - 1;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_key_record, i_key_play, i_key_pause, i_key_stop;
    logic [2:0]        i_speed;
    logic              i_fast, i_interp;
    logic              o_rec_start, o_rec_pause, o_rec_stop;
    logic              i_rec_we;
    logic [ADDR_W-1:0] i_rec_addr;
    logic [15:0]       i_rec_data;
    logic              o_dsp_start, o_dsp_pause, o_dsp_stop;
    logic [2:0]        o_dsp_speed;
    logic              o_dsp_fast, o_dsp_interp;
    logic [ADDR_W-1:0] i_dsp_addr;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [15:0]       o_sram_wdata;
    logic              o_sram_we_n, o_sram_oe_n;
    logic [2:0]        o_state;
    logic [ADDR_W-1:0] o_rec_len;

    always #5 i_clk = ~i_clk;

    aud_mode_ctrl #(.ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_key_record(i_key_record), .i_key_play(i_key_play),
        .i_key_pause(i_key_pause), .i_key_stop(i_key_stop),
        .i_speed(i_speed), .i_fast(i_fast), .i_interp(i_interp),
        .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause),
        .o_rec_stop(o_rec_stop), .i_rec_we(i_rec_we),
        .i_rec_addr(i_rec_addr), .i_rec_data(i_rec_data),
        .o_dsp_start(o_dsp_start), .o_dsp_pause(o_dsp_pause),
        .o_dsp_stop(o_dsp_stop), .o_dsp_speed(o_dsp_speed),
        .o_dsp_fast(o_dsp_fast), .o_dsp_interp(o_dsp_interp),
        .i_dsp_addr(i_dsp_addr), .o_sram_addr(o_sram_addr),
        .o_sram_wdata(o_sram_wdata), .o_sram_we_n(o_sram_we_n),
        .o_sram_oe_n(o_sram_oe_n), .o_state(o_state),
        .o_rec_len(o_rec_len)
    );

    int checks = 0;
    int errors = 0;

    // Model: mode number as listed in the mode table, length in words
    int          m_mode;
    int unsigned m_len;
    int unsigned m_speed;
    bit          m_fast, m_interp;
    bit          m_rs, m_rp, m_rt, m_ds, m_dp, m_dt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit stop_now;
        {m_rs, m_rp, m_rt, m_ds, m_dp, m_dt} = '0;
        if (!i_rst_n) begin
            m_mode = 0; m_len = 0;
            m_speed = 1; m_fast = 0; m_interp = 0;
            return;
        end
        case (m_mode)
            0: if (i_key_record) begin
                   m_mode = 1; m_len = 0; m_rs = 1;
               end else if (i_key_play && m_len > 0) begin
                   m_mode = 3; m_ds = 1;
                   m_speed = (i_speed == 0) ? 1 : int'(i_speed);
                   m_fast = i_fast; m_interp = i_interp;
               end
            1: begin
                   if (i_rec_we)
                       m_len = (int'(i_rec_addr) + 1 > MAX_ADDR + 1) ?
                               MAX_ADDR + 1 : int'(i_rec_addr) + 1;
                   stop_now = i_key_stop ||
                              (i_rec_we && i_rec_addr == ADDR_W'(MAX_ADDR));
                   if (stop_now) begin m_mode = 0; m_rt = 1; end
                   else if (i_key_pause) begin m_mode = 2; m_rp = 1; end
               end
            2: if (i_key_stop) begin m_mode = 0; m_rt = 1; end
               else if (i_key_record) begin m_mode = 1; m_rs = 1; end
            3: if (i_key_stop || int'(i_dsp_addr) >= m_len) begin
                   m_mode = 0; m_dt = 1;
               end else if (i_key_pause) begin m_mode = 4; m_dp = 1; end
            4: if (i_key_stop) begin m_mode = 0; m_dt = 1; end
               else if (i_key_play) begin m_mode = 3; m_ds = 1; end
            default: m_mode = 0;
        endcase
    endtask

    task automatic check_all();
        logic [31:0] ea, ew;
        logic        ewe, eoe;
        ea = 0; ew = 0; ewe = 1; eoe = 1;
        if (m_mode == 1) begin
            ea = i_rec_addr; ew = i_rec_data; ewe = ~i_rec_we;
        end else if (m_mode == 3 || m_mode == 4) begin
            ea = i_dsp_addr; eoe = 0;
        end
        chk("state", o_state, m_mode);
        chk("rec_len", o_rec_len,
            (m_len > MAX_ADDR) ? 32'hFFFFF : m_len);
        chk("rec_start", o_rec_start, m_rs);
        chk("rec_pause", o_rec_pause, m_rp);
        chk("rec_stop", o_rec_stop, m_rt);
        chk("dsp_start", o_dsp_start, m_ds);
        chk("dsp_pause", o_dsp_pause, m_dp);
        chk("dsp_stop", o_dsp_stop, m_dt);
        chk("dsp_speed", o_dsp_speed, m_speed);
        chk("dsp_fast", o_dsp_fast, m_fast);
        chk("dsp_interp", o_dsp_interp, m_interp);
        chk("sram_addr", o_sram_addr, ea);
        chk("sram_wdata", o_sram_wdata, ew);
        chk("sram_we_n", o_sram_we_n, ewe);
        chk("sram_oe_n", o_sram_oe_n, eoe);
    endtask

    task automatic step();
        @(posedge i_clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic key(input bit r, input bit p, input bit pa, input bit s);
        i_key_record = r; i_key_play = p;
        i_key_pause = pa; i_key_stop = s;
        step();
        {i_key_record, i_key_play, i_key_pause, i_key_stop} = '0;
    endtask

    initial begin
        int n_stop;
        i_rst_n = 0;
        {i_key_record, i_key_play, i_key_pause, i_key_stop} = '0;
        i_speed = 0; i_fast = 0; i_interp = 0;
        i_rec_we = 0; i_rec_addr = 0; i_rec_data = 0; i_dsp_addr = 0;
        m_mode = 0; m_len = 0; m_speed = 1; m_fast = 0; m_interp = 0;
        {m_rs, m_rp, m_rt, m_ds, m_dp, m_dt} = '0;

        repeat (3) step();
        chk("reset_state", o_state, 0);
        chk("reset_speed", o_dsp_speed, 1);
        i_rst_n = 1;

        // play with nothing recorded is ignored
        key(0, 1, 0, 0);
        chk("empty_play_state", o_state, 0);
        chk("empty_play_oe", o_sram_oe_n, 1);
        step();

        // record 100 words, writes on alternate cycles
        key(1, 0, 0, 0);
        for (int a = 0; a < 100; a++) begin
            i_rec_addr = ADDR_W'(a); i_rec_data = 16'($urandom);
            i_rec_we = 1; step();
            i_rec_we = 0; step();
        end
        key(0, 0, 0, 1);
        chk("rec_len_100", o_rec_len, 100);
        chk("rec_done_state", o_state, 0);

        // play to the end, speed change mid-play not latched
        i_speed = 3; i_fast = 1; i_dsp_addr = 0;
        key(0, 1, 0, 0);
        i_speed = 5;
        n_stop = 0;
        for (int a = 1; a <= 100; a++) begin
            i_dsp_addr = ADDR_W'(a); step();
            if (o_dsp_stop) n_stop++;
        end
        step();
        if (o_dsp_stop) n_stop++;
        chk("dsp_stop_once", n_stop, 1);
        chk("speed_held", o_dsp_speed, 3);
        chk("play_done_state", o_state, 0);
        i_dsp_addr = 0;

        // record / pause / resume / stop
        key(1, 0, 0, 0);
        for (int a = 0; a < 50; a++) begin
            i_rec_addr = ADDR_W'(a); i_rec_we = 1; step();
        end
        i_rec_we = 0;
        key(0, 0, 1, 0);
        i_rec_addr = 200; i_rec_we = 1;
        repeat (3) step();
        i_rec_we = 0;
        key(1, 0, 0, 0);
        for (int a = 50; a < 100; a++) begin
            i_rec_addr = ADDR_W'(a); i_rec_we = 1; step();
        end
        i_rec_we = 0;
        key(0, 0, 0, 1);
        chk("resume_len_100", o_rec_len, 100);

        // stop+pause together in PLAY, record+play together in IDLE
        i_speed = 0; i_fast = 0; i_interp = 1;
        key(0, 1, 0, 0);
        chk("speed0_as_1", o_dsp_speed, 1);
        step();
        key(0, 0, 1, 1);
        chk("stop_pause_state", o_state, 0);
        key(1, 1, 0, 0);
        chk("rec_over_play", o_state, 1);
        key(0, 0, 0, 1);

        // full memory auto-stop, alone and with a stop key
        key(1, 0, 0, 0);
        i_rec_addr = ADDR_W'(MAX_ADDR); i_rec_we = 1;
        step();
        i_rec_we = 0;
        chk("full_state", o_state, 0);
        chk("full_stop", o_rec_stop, 1);
        step();
        key(1, 0, 0, 0);
        i_rec_we = 1;
        key(0, 0, 0, 1);
        i_rec_we = 0;
        step();
        chk("full_len", o_rec_len, 32'hFFFFF);

        // reset during playback
        i_dsp_addr = 5;
        key(0, 1, 0, 0);
        step();
        i_rst_n = 0;
        step();
        chk("rst_play_state", o_state, 0);
        chk("rst_play_len", o_rec_len, 0);
        chk("rst_no_stop", o_dsp_stop, 0);
        i_rst_n = 1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            i_rst_n      = ($urandom_range(0, 399) != 0);
            i_key_record = ($urandom_range(0, 9) == 0);
            i_key_play   = ($urandom_range(0, 9) == 0);
            i_key_pause  = ($urandom_range(0, 12) == 0);
            i_key_stop   = ($urandom_range(0, 24) == 0);
            i_speed      = 3'($urandom);
            i_fast       = 1'($urandom);
            i_interp     = 1'($urandom);
            i_rec_we     = 1'($urandom);
            i_rec_data   = 16'($urandom);
            i_rec_addr   = ($urandom_range(0, 199) == 0) ?
                           ADDR_W'(MAX_ADDR) : ADDR_W'($urandom_range(0, 150));
            i_dsp_addr   = ADDR_W'($urandom_range(0, 160));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
